// File: rtl/adc_sequencer.sv
// adc_sequencer: round-robin scanner for the ADC macro, feeding value_storage.
// Walks the enabled channels (chan_mask, sampled only between conversions),
// settles adc_chnum, issues one-cycle adc_start pulses, averages
// 2^AVG_LOG2 conversions per channel and presents the result as a
// single-cycle adc_strb with adc_channel/adc_result. A conversion that never
// returns adc_datavalid is abandoned after TIMEOUT_CYCLES with timeout_err.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              scan enable
//   chan_mask[31:0]     per-channel enable, bit n enables channel n
//   adc_chnum[4:0]      channel select to the ADC macro
//   adc_start           one-cycle conversion start pulse
//   adc_busy            ADC converting (start is held off while high)
//   adc_datavalid       one-cycle pulse qualifying adc_data
//   adc_data[11:0]      raw conversion result
//   adc_strb            one-cycle result strobe
//   adc_channel[4:0]    channel of the current/last result
//   adc_result[11:0]    averaged result
//   timeout_err         one-cycle pulse on conversion timeout
module adc_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 32,   // 1..32
  parameter int unsigned AVG_LOG2       = 2,    // 0..4
  parameter int unsigned SETTLE_CYCLES  = 4,    // >= 1
  parameter int unsigned TIMEOUT_CYCLES = 1023  // >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] chan_mask,
  output logic [4:0]  adc_chnum,
  output logic        adc_start,
  input  logic        adc_busy,
  input  logic        adc_datavalid,
  input  logic [11:0] adc_data,
  output logic        adc_strb,
  output logic [4:0]  adc_channel,
  output logic [11:0] adc_result,
  output logic        timeout_err
);

  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END    = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  state_t             r_state;
  logic [4:0]         r_chan;
  logic [ACC_W-1:0]   r_acc;
  logic [SMP_W-1:0]   r_smp;
  logic [SET_W-1:0]   r_settle;
  logic [TMO_W-1:0]   r_tmo;

  logic [4:0]         w_next_chan;
  logic               w_any;
  logic [ACC_W-1:0]   w_sum;
  logic [11:0]        w_avg;

  // Next enabled channel strictly after r_chan, wrapping; offset NUM_CHANNELS
  // lands back on r_chan itself so a lone enabled channel is reselected.
  // Descending scan: the smallest matching offset is assigned last and wins.
  always_comb begin
    w_next_chan = r_chan;
    w_any       = 1'b0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      int unsigned idx;
      idx = (int'(r_chan) + i) % NUM_CHANNELS;
      if (chan_mask[idx]) begin
        w_next_chan = 5'(idx);
        w_any       = 1'b1;
      end
    end
  end

  // Accumulate including the sample arriving this cycle so the strobe can
  // be registered on the final datavalid (one cycle of latency).
  always_comb begin
    w_sum = r_acc + ACC_W'(adc_data);
    w_avg = 12'(w_sum >> AVG_LOG2);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_chan      <= 5'(NUM_CHANNELS - 1);
      r_acc       <= '0;
      r_smp       <= '0;
      r_settle    <= '0;
      r_tmo       <= '0;
      adc_chnum   <= '0;
      adc_start   <= 1'b0;
      adc_strb    <= 1'b0;
      adc_channel <= '0;
      adc_result  <= '0;
      timeout_err <= 1'b0;
    end else begin
      adc_start   <= 1'b0;
      adc_strb    <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && w_any) begin
            r_chan    <= w_next_chan;
            adc_chnum <= w_next_chan;
            r_acc     <= '0;
            r_smp     <= '0;
            r_settle  <= '0;
            r_state   <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_settle == SETTLE_END) begin
            r_state <= S_START;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        S_START: begin
          if (!adc_busy) begin
            adc_start <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (adc_datavalid) begin
            r_acc <= w_sum;
            if (r_smp == SMP_LAST) begin
              // Strobe is visible during the EMIT cycle.
              adc_strb    <= 1'b1;
              adc_result  <= w_avg;
              adc_channel <= r_chan;
              r_state     <= S_EMIT;
            end else begin
              r_smp   <= r_smp + SMP_W'(1);
              r_state <= S_START;
            end
          end else if (r_tmo == TMO_END) begin
            // Abandon this channel; IDLE moves on to the next one.
            timeout_err <= 1'b1;
            r_acc       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_EMIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed testbench for adc_sequencer. Two instances: u_dut0 (no averaging)
// for scan order, timeout, busy, mask, enable and reset behaviour; u_dut2
// (AVG_LOG2=2) for averaging. The ADC model raises datavalid two cycles after
// the start-pulse cycle (three-cycle conversion counting the start cycle).
module tb_adc_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 1023;
  localparam int unsigned GAP    = SETTLE + 6;

  logic        clk;
  logic        reset;

  // Instance 0 signals
  logic        enable;
  logic [31:0] chan_mask;
  logic [4:0]  adc_chnum;
  logic        adc_start;
  logic        adc_busy;
  logic        adc_datavalid;
  logic [11:0] adc_data;
  logic        adc_strb;
  logic [4:0]  adc_channel;
  logic [11:0] adc_result;
  logic        timeout_err;

  // Instance 2 signals
  logic        en2;
  logic [31:0] mask2;
  logic [4:0]  chnum2;
  logic        start2;
  logic        dv2;
  logic [11:0] data2;
  logic        strb2;
  logic [4:0]  ch2;
  logic [11:0] res2;
  logic        tmo2;

  adc_sequencer #(.NUM_CHANNELS(32), .AVG_LOG2(0), .SETTLE_CYCLES(SETTLE),
                  .TIMEOUT_CYCLES(TMO)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .adc_chnum(adc_chnum), .adc_start(adc_start), .adc_busy(adc_busy),
    .adc_datavalid(adc_datavalid), .adc_data(adc_data), .adc_strb(adc_strb),
    .adc_channel(adc_channel), .adc_result(adc_result), .timeout_err(timeout_err));

  adc_sequencer #(.NUM_CHANNELS(32), .AVG_LOG2(2), .SETTLE_CYCLES(SETTLE),
                  .TIMEOUT_CYCLES(TMO)) u_dut2 (
    .clk(clk), .reset(reset), .enable(en2), .chan_mask(mask2),
    .adc_chnum(chnum2), .adc_start(start2), .adc_busy(1'b0),
    .adc_datavalid(dv2), .adc_data(data2), .adc_strb(strb2),
    .adc_channel(ch2), .adc_result(res2), .timeout_err(tmo2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model for instance 0: result 1024+chnum, hang_ch never answers.
  logic        m_p1;
  logic [11:0] m_d1;
  logic        force_busy;
  int          hang_ch;
  initial begin
    m_p1 = 1'b0; m_d1 = '0; adc_datavalid = 1'b0; adc_data = '0;
  end
  always @(posedge clk) begin
    m_p1          <= adc_start && (int'(adc_chnum) != hang_ch);
    m_d1          <= 12'(1024 + int'(adc_chnum));
    adc_datavalid <= m_p1;
    adc_data      <= m_d1;
  end
  assign adc_busy = m_p1 | force_busy;

  // ADC model for instance 2: returns 100,101,102,104 repeating.
  logic m2_p1;
  int   v_idx;
  initial begin m2_p1 = 1'b0; dv2 = 1'b0; data2 = '0; v_idx = 0; end
  always @(posedge clk) begin
    m2_p1 <= start2;
    dv2   <= m2_p1;
    if (m2_p1) begin
      case (v_idx % 4)
        0:       data2 <= 12'd100;
        1:       data2 <= 12'd101;
        2:       data2 <= 12'd102;
        default: data2 <= 12'd104;
      endcase
      v_idx <= v_idx + 1;
    end
  end

  // Monitors
  int          cyc = 0;
  int          n_start = 0;
  int          n_tmo = 0;
  int          n_start2 = 0;
  int          last_start_cyc = 0;
  int          last_start_ch = 0;
  int          dbl_start = 0;
  logic        prev_start = 1'b0;
  int          s_ch[$];
  int          s_res[$];
  int          s_cyc[$];
  int          t_diff[$];
  int          t_ch[$];
  always @(posedge clk) begin
    if (adc_strb) begin
      s_ch.push_back(int'(adc_channel));
      s_res.push_back(int'(adc_result));
      s_cyc.push_back(cyc);
    end
    if (timeout_err) begin
      n_tmo <= n_tmo + 1;
      t_diff.push_back(cyc - last_start_cyc);
      t_ch.push_back(last_start_ch);
    end
    if (adc_start) begin
      n_start        <= n_start + 1;
      last_start_cyc <= cyc;
      last_start_ch  <= int'(adc_chnum);
      if (prev_start) dbl_start <= dbl_start + 1;
    end
    if (start2) n_start2 <= n_start2 + 1;
    prev_start <= adc_start;
    cyc        <= cyc + 1;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while (s_ch.size() < n && b > 0) begin
      tick();
      b--;
    end
    check({tag, "_wait"}, 64'(s_ch.size() >= n), 64'd1);
  endtask

  int base;
  int snap_s;
  int snap_t;
  int b;

  initial begin
    reset = 1'b1; enable = 1'b0; chan_mask = '0; force_busy = 1'b0;
    hang_ch = 99; en2 = 1'b0; mask2 = '0;
    do_reset();

    // Reset state
    check("rst_chnum",   64'(adc_chnum),   64'd0);
    check("rst_start",   64'(adc_start),   64'd0);
    check("rst_strb",    64'(adc_strb),    64'd0);
    check("rst_channel", 64'(adc_channel), 64'd0);
    check("rst_result",  64'(adc_result),  64'd0);
    check("rst_tmo",     64'(timeout_err), 64'd0);

    // enable=0, then mask=0: no activity
    snap_s = n_start; base = s_ch.size();
    chan_mask = 32'hFFFF_FFFF;
    repeat (1000) tick();
    check("en0_starts", 64'(n_start - snap_s), 64'd0);
    check("en0_strobes", 64'(s_ch.size() - base), 64'd0);
    enable = 1'b1; chan_mask = '0;
    repeat (1000) tick();
    check("mask0_starts", 64'(n_start - snap_s), 64'd0);
    check("mask0_strobes", 64'(s_ch.size() - base), 64'd0);

    // Full scan 0..31,0 with fixed strobe spacing
    enable = 1'b0;
    do_reset();
    base = s_ch.size();
    enable = 1'b1; chan_mask = 32'hFFFF_FFFF;
    wait_strobes(base + 33, 2000, "scan");
    enable = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (base + i < s_ch.size()) begin
        check($sformatf("scan_ch%0d", i), 64'(s_ch[base+i]), 64'(i % 32));
        check($sformatf("scan_res%0d", i), 64'(s_res[base+i]), 64'(1024 + i % 32));
        if (i > 0)
          check($sformatf("scan_gap%0d", i), 64'(s_cyc[base+i] - s_cyc[base+i-1]), 64'(GAP));
      end
    end
    check("start_width", 64'(dbl_start), 64'd0);
    // enable low: in-flight channel finishes, then parks
    repeat (40) tick();
    snap_s = n_start;
    repeat (100) tick();
    check("park_starts", 64'(n_start - snap_s), 64'd0);

    // Mask 0x11 alternates 0,4; mask change mid-conversion of channel 4
    do_reset();
    base = s_ch.size();
    enable = 1'b1; chan_mask = 32'h0000_0011;
    wait_strobes(base + 3, 500, "alt");
    b = 100;
    while (!(adc_start && adc_chnum == 5'd4) && b > 0) begin
      tick();
      b--;
    end
    check("alt_start4", 64'(adc_start && adc_chnum == 5'd4), 64'd1);
    chan_mask = 32'h0000_0100;
    wait_strobes(base + 6, 500, "alt2");
    enable = 1'b0;
    begin
      int exp_seq[6] = '{0, 4, 0, 4, 8, 8};
      for (int i = 0; i < 6; i++)
        if (base + i < s_ch.size())
          check($sformatf("alt_ch%0d", i), 64'(s_ch[base+i]), 64'(exp_seq[i]));
    end
    repeat (40) tick();

    // Timeout on channel 3, scanning continues 1,2,1,2
    do_reset();
    base = s_ch.size(); snap_t = t_diff.size();
    hang_ch = 3;
    enable = 1'b1; chan_mask = 32'h0000_000E;
    wait_strobes(base + 4, 3000, "tmo");
    enable = 1'b0;
    for (int i = 0; i < 4; i++)
      if (base + i < s_ch.size())
        check($sformatf("tmo_ch%0d", i), 64'(s_ch[base+i]), 64'(1 + i % 2));
    check("tmo_count", 64'(t_diff.size() - snap_t), 64'd1);
    if (t_diff.size() > snap_t) begin
      check("tmo_delay", 64'(t_diff[snap_t]), 64'(TMO));
      check("tmo_chan",  64'(t_ch[snap_t]),   64'd3);
    end
    repeat (1100) tick();
    hang_ch = 99;

    // adc_busy held high in START; single channel reselected each pass
    do_reset();
    base = s_ch.size(); snap_s = n_start;
    force_busy = 1'b1;
    enable = 1'b1; chan_mask = 32'h0000_0001;
    repeat (16) tick();
    check("busy_nostart", 64'(n_start - snap_s), 64'd0);
    force_busy = 1'b0;
    tick();
    check("busy_start1", 64'(adc_start), 64'd1);
    tick();
    check("busy_start0", 64'(adc_start), 64'd0);
    wait_strobes(base + 2, 200, "single");
    enable = 1'b0;
    if (s_ch.size() >= base + 2) begin
      check("single_ch0", 64'(s_ch[base]),   64'd0);
      check("single_ch1", 64'(s_ch[base+1]), 64'd0);
      check("single_gap", 64'(s_cyc[base+1] - s_cyc[base]), 64'(GAP));
    end
    repeat (40) tick();

    // Averaging: channel 5, samples 100,101,102,104 -> 407>>2 = 101
    en2 = 1'b1; mask2 = 32'h0000_0020;
    snap_s = n_start2;
    b = 300;
    while (!strb2 && b > 0) begin
      tick();
      b--;
    end
    check("avg_strobe", 64'(strb2), 64'd1);
    check("avg_ch",     64'(ch2),   64'd5);
    check("avg_res",    64'(res2),  64'd101);
    check("avg_starts", 64'(n_start2 - snap_s), 64'd4);
    en2 = 1'b0;
    repeat (60) tick();

    // Reset mid-WAIT: outputs clear, then restart from the lowest channel
    do_reset();
    base = s_ch.size();
    enable = 1'b1; chan_mask = 32'h0000_0006;
    wait_strobes(base + 1, 200, "rw");
    b = 100;
    while (!(adc_start && adc_chnum == 5'd2) && b > 0) begin
      tick();
      b--;
    end
    check("rw_start2", 64'(adc_start), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rw_chnum",   64'(adc_chnum),   64'd0);
    check("rw_channel", 64'(adc_channel), 64'd0);
    check("rw_result",  64'(adc_result),  64'd0);
    check("rw_strb",    64'(adc_strb),    64'd0);
    check("rw_tmo",     64'(timeout_err), 64'd0);
    snap_s = n_start;
    tick();
    check("rw_start_hold", 64'(adc_start), 64'd0);
    reset = 1'b0;
    check("rw_nostart", 64'(n_start - snap_s), 64'd0);
    base = s_ch.size();
    wait_strobes(base + 1, 200, "rw_after");
    if (s_ch.size() > base) begin
      check("rw_first_ch",  64'(s_ch[base]),  64'd1);
      check("rw_first_res", 64'(s_res[base]), 64'd1025);
    end
    enable = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
